// File: rtl/wave_prof_buffer.sv
// Double-buffered wave-profile store feeding the pixel pipeline.
// Define WAVE_PREV_EN to keep a third bank and serve the previous frame.
module wave_prof_buffer #(
   parameter int WIDTH_PX = 1024,
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wave_we,
   input  logic [10:0]       wave_index,
   input  logic [DATA_W-1:0] wave_prof,
   output logic              buf_ready,
   input  logic [10:0]       p_offset,
   input  logic              vsync,
   input  logic [10:0]       hcount,
   output logic [DATA_W-1:0] height,
   output logic              height_vld,
   output logic              frame_swap,
   output logic [DATA_W-1:0] prev_height
);

`ifdef WAVE_PREV_EN
   localparam int NBANK = 3;
   localparam int SEL_W = 2;
`else
   localparam int NBANK = 2;
   localparam int SEL_W = 1;
`endif
   localparam int DEPTH = NBANK * WIDTH_PX;
   localparam int MA_W = SEL_W + ADDR_W;
   localparam logic [10:0] LIMIT = 11'(WIDTH_PX);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH_PX - 1);

   function automatic logic [MA_W-1:0] bank_addr(
      input logic [SEL_W-1:0]  sel,
      input logic [ADDR_W-1:0] addr
   );
      return {sel, addr};
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [SEL_W-1:0]  front_sel_q, front_sel_d;
   logic [SEL_W-1:0]  back_sel_q, back_sel_d;
   logic              back_full_q, back_full_d;
   logic              front_vld_q, front_vld_d;
   logic [ADDR_W-1:0] offset_q, offset_d;
   logic              vsync_q;
   logic              frame_swap_q;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              swap;

   logic [ADDR_W-1:0] rd_addr;
   logic              in_range;
   logic [DATA_W-1:0] rd_q;
   logic              vld1_q;
   logic [DATA_W-1:0] height_q;
   logic              height_vld_q;

   // only the low ADDR_W bits of the scroll offset matter
   logic unused_ofs;
   assign unused_ofs = ^p_offset;

   // ---------------- write side and bank control ----------------
   always_comb begin
      wr_en   = wave_we && (wave_index < LIMIT);
      wr_addr = wave_index[ADDR_W-1:0];
      swap    = vsync && !vsync_q && back_full_q;
   end

`ifdef WAVE_PREV_EN
   logic [SEL_W-1:0] prev_sel_q, prev_sel_d;
   logic             prev_vld_q, prev_vld_d;
`endif

   always_comb begin
      back_full_d = back_full_q;
      front_sel_d = front_sel_q;
      back_sel_d  = back_sel_q;
      front_vld_d = front_vld_q;
      offset_d    = offset_q;
`ifdef WAVE_PREV_EN
      prev_sel_d  = prev_sel_q;
      prev_vld_d  = prev_vld_q;
`endif
      if (wr_en && wr_addr == LAST) begin
         back_full_d = 1'b1;
      end else if (wr_en && wr_addr == '0) begin
         back_full_d = 1'b0;
      end
      // the swap empties the back bank even if a write lands this cycle
      if (swap) begin
         back_full_d = 1'b0;
         front_sel_d = back_sel_q;
         front_vld_d = 1'b1;
         offset_d    = p_offset[ADDR_W-1:0];
`ifdef WAVE_PREV_EN
         prev_sel_d  = front_sel_q;
         back_sel_d  = prev_sel_q;
         prev_vld_d  = front_vld_q;
`else
         back_sel_d  = front_sel_q;
`endif
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         front_sel_q  <= SEL_W'(0);
         back_sel_q   <= SEL_W'(1);
         back_full_q  <= 1'b0;
         front_vld_q  <= 1'b0;
         offset_q     <= '0;
         vsync_q      <= 1'b0;
         frame_swap_q <= 1'b0;
      end else begin
         front_sel_q  <= front_sel_d;
         back_sel_q   <= back_sel_d;
         back_full_q  <= back_full_d;
         front_vld_q  <= front_vld_d;
         offset_q     <= offset_d;
         vsync_q      <= vsync;
         frame_swap_q <= swap;
      end
   end

`ifdef WAVE_PREV_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_sel_q <= SEL_W'(2);
         prev_vld_q <= 1'b0;
      end else begin
         prev_sel_q <= prev_sel_d;
         prev_vld_q <= prev_vld_d;
      end
   end
`endif

   // ---------------- read pipeline ----------------
   always_comb begin
      rd_addr  = hcount[ADDR_W-1:0] + offset_q;
      in_range = hcount < LIMIT;
   end

   // bank select is taken here at S0, so a read never straddles a swap
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[bank_addr(back_sel_q, wr_addr)] <= wave_prof;
      end
      rd_q <= mem_q[bank_addr(front_sel_q, rd_addr)];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld1_q       <= 1'b0;
         height_q     <= '0;
         height_vld_q <= 1'b0;
      end else begin
         vld1_q       <= in_range && front_vld_q;
         height_q     <= vld1_q ? rd_q : '0;
         height_vld_q <= vld1_q;
      end
   end

`ifdef WAVE_PREV_EN
   logic [DATA_W-1:0] prd_q;
   logic              pvld1_q;
   logic [DATA_W-1:0] prev_height_q;

   always_ff @(posedge clock) begin
      prd_q <= mem_q[bank_addr(prev_sel_q, rd_addr)];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pvld1_q       <= 1'b0;
         prev_height_q <= '0;
      end else begin
         pvld1_q       <= in_range && prev_vld_q;
         prev_height_q <= pvld1_q ? prd_q : '0;
      end
   end

   assign prev_height = prev_height_q;
`else
   assign prev_height = '0;
`endif

   assign buf_ready  = !back_full_q;
   assign height     = height_q;
   assign height_vld = height_vld_q;
   assign frame_swap = frame_swap_q;

endmodule
